unidade_div: RTL

- Iterative signed 32-bit divider; the responder on the DivCtrl/DivOut/divZero handshake driven by the multicycle control unit.
- Computes quotient to LO and remainder to HI with one restoring step per clock.
- Sits in the datapath beside the HI/LO registers. The control unit waits in its DIV state until done or div_zero is asserted.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_passo.sv | 24 ++
 rtl/unidade_div.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider (unidade_div and div_passo).
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    FIX  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_passo.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module div_passo #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // One extra bit so an unsigned divisor near 2^WIDTH cannot overflow the shift.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, q_msb_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/unidade_div.sv
// Iterative signed divider: quotient to lo, remainder to hi, one step per clock.
// Define UNIDADE_DIV_UNSIGNED_EN to add the is_unsigned input (divu behaviour).
//
// Handshake: start is a level request, accepted only in IDLE while armed; busy
// is high from the accept edge until the result or error pulse; done and
// div_zero are single-cycle pulses; start must drop for one edge to re-arm.
module unidade_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef UNIDADE_DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output div_state_t       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dvd_neg_q, dvd_neg_d;
  logic             quo_neg_q, quo_neg_d;
  logic             armed_q, armed_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             signed_mode;
  logic             dvd_neg_w;
  logic             dvs_neg_w;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             accept;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

`ifdef UNIDADE_DIV_UNSIGNED_EN
  assign signed_mode = ~is_unsigned;
`else
  assign signed_mode = 1'b1;
`endif

  // Unsigned requests clear both sign flags, so FIX needs no mode of its own.
  assign dvd_neg_w = signed_mode & dividend[WIDTH-1];
  assign dvs_neg_w = signed_mode & divisor[WIDTH-1];
  assign dvd_abs   = dvd_neg_w ? (~dividend + 1'b1) : dividend;
  assign dvs_abs   = dvs_neg_w ? (~divisor + 1'b1) : divisor;
  assign accept    = (state_q == IDLE) && start && armed_q;

  div_passo #(
    .WIDTH(WIDTH)
  ) u_passo (
    .rem_i    (rem_q),
    .q_msb_i  (q_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (divisor == '0) ? ERR : RUN;
        end
      end
      RUN: begin
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    rem_d     = rem_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    dvd_neg_d = dvd_neg_q;
    quo_neg_d = quo_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    armed_d   = start ? armed_q : 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dvd_neg_d = dvd_neg_w;
          quo_neg_d = dvd_neg_w ^ dvs_neg_w;
          q_d       = dvd_abs;
          dvs_d     = dvs_abs;
          rem_d     = '0;
          count_d   = '0;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        rem_d   = step_rem;
        q_d     = {q_q[WIDTH-2:0], step_bit};
        count_d = count_q + 1'b1;
      end
      FIX: begin
        lo_d   = quo_neg_q ? (~q_q + 1'b1) : q_q;
        hi_d   = dvd_neg_q ? (~rem_q + 1'b1) : rem_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      DONE: begin
        if (start) armed_d = 1'b0;
      end
      ERR: begin
        dz_d   = 1'b1;
        busy_d = 1'b0;
        if (start) armed_d = 1'b0;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      dvd_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
      armed_q   <= 1'b1;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      dvs_q     <= dvs_d;
      dvd_neg_q <= dvd_neg_d;
      quo_neg_q <= quo_neg_d;
      armed_q   <= armed_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule
